// File: rtl/decode_pkg.sv
// Shared RV32I decode encodings and the decoded-field bundle for id_stage.
// Define DECODE_MEXT_EN to decode the M extension (ALU_W becomes 5).
package decode_pkg;

`ifdef DECODE_MEXT_EN
    localparam int unsigned ALU_W_DEF = 5;
`else
    localparam int unsigned ALU_W_DEF = 4;
`endif

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_RTYPE  = 7'h33;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_MEM_B  = 3'd0;
    localparam logic [2:0] F3_MEM_H  = 3'd1;
    localparam logic [2:0] F3_MEM_W  = 3'd2;
    localparam logic [2:0] F3_MEM_BU = 3'd4;
    localparam logic [2:0] F3_MEM_HU = 3'd5;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MEXT = 7'h01;

    typedef enum logic [4:0] {
        ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_XOR,
        ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
        ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU,
        ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU
    } alu_op_e;

    typedef enum logic [1:0] {OPSEL_RS1, OPSEL_PC, OPSEL_ZERO} opsel1_e;
    typedef enum logic [1:0] {OPSEL_RS2, OPSEL_IMM, OPSEL_FOUR} opsel2_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_e;
    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP
    } br_e;
    typedef enum logic [1:0] {MEM_SIZE_B, MEM_SIZE_H, MEM_SIZE_W} mem_size_e;
    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
    } imm_type_e;

    typedef struct packed {
        alu_op_e   alu_op;
        opsel1_e   opsel1;
        opsel2_e   opsel2;
        wb_e       wbsel;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic      rf_w_en;
        logic      mem_w_en;
        logic      mem_r_en;
        mem_size_e mem_size;
        logic      mem_uns;
        br_e       br_type;
        logic      jalr;
        logic      illegal;
    } decode_t;

    // Every field at its all-zero encoding; also the illegal-op payload.
    localparam decode_t DECODE_SET = '{
        alu_op: ALU_OP_ADD, opsel1: OPSEL_RS1, opsel2: OPSEL_RS2, wbsel: WB_ALU,
        rs1_addr: 5'd0, rs2_addr: 5'd0, rd_addr: 5'd0,
        rf_w_en: 1'b0, mem_w_en: 1'b0, mem_r_en: 1'b0,
        mem_size: MEM_SIZE_B, mem_uns: 1'b0, br_type: BR_NONE,
        jalr: 1'b0, illegal: 1'b0
    };

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational RV32I decoder: raw instruction -> control bundle + immediate.
// M-extension encodings are decoded only when DECODE_MEXT_EN is defined.
module id_decode_comb
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_inst,
    output decode_t         o_ctrl,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    imm_type_e  w_imm_type;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_use_rd;
    logic       w_ill;
    decode_t    w_d;
    logic [31:0] w_imm32;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];

    always_comb begin
        w_d        = DECODE_SET;
        w_imm_type = IMM_NONE;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        w_use_rd   = 1'b0;
        w_ill      = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_d.opsel1 = OPSEL_ZERO;
                w_d.opsel2 = OPSEL_IMM;
                w_imm_type = IMM_U;
                w_use_rd   = 1'b1;
            end
            OP_AUIPC: begin
                w_d.opsel1 = OPSEL_PC;
                w_d.opsel2 = OPSEL_IMM;
                w_imm_type = IMM_U;
                w_use_rd   = 1'b1;
            end
            OP_JAL: begin
                w_d.opsel1  = OPSEL_PC;
                w_d.opsel2  = OPSEL_IMM;
                w_d.wbsel   = WB_PC4;
                w_d.br_type = BR_JUMP;
                w_imm_type  = IMM_J;
                w_use_rd    = 1'b1;
            end
            OP_JALR: begin
                w_ill       = (w_funct3 != 3'd0);
                w_d.opsel2  = OPSEL_IMM;
                w_d.wbsel   = WB_PC4;
                w_d.br_type = BR_JUMP;
                w_d.jalr    = 1'b1;
                w_imm_type  = IMM_I;
                w_use_rs1   = 1'b1;
                w_use_rd    = 1'b1;
            end
            OP_BRANCH: begin
                w_d.alu_op = ALU_OP_SUB;
                w_imm_type = IMM_B;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                case (w_funct3)
                    F3_BEQ:  w_d.br_type = BR_EQ;
                    F3_BNE:  w_d.br_type = BR_NE;
                    F3_BLT:  w_d.br_type = BR_LT;
                    F3_BGE:  w_d.br_type = BR_GE;
                    F3_BLTU: w_d.br_type = BR_LTU;
                    F3_BGEU: w_d.br_type = BR_GEU;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_d.opsel2   = OPSEL_IMM;
                w_d.wbsel    = WB_MEM;
                w_d.mem_r_en = 1'b1;
                w_imm_type   = IMM_I;
                w_use_rs1    = 1'b1;
                w_use_rd     = 1'b1;
                case (w_funct3)
                    F3_MEM_B:  w_d.mem_size = MEM_SIZE_B;
                    F3_MEM_H:  w_d.mem_size = MEM_SIZE_H;
                    F3_MEM_W:  w_d.mem_size = MEM_SIZE_W;
                    F3_MEM_BU: begin w_d.mem_size = MEM_SIZE_B; w_d.mem_uns = 1'b1; end
                    F3_MEM_HU: begin w_d.mem_size = MEM_SIZE_H; w_d.mem_uns = 1'b1; end
                    default:   w_ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_d.opsel2   = OPSEL_IMM;
                w_d.mem_w_en = 1'b1;
                w_imm_type   = IMM_S;
                w_use_rs1    = 1'b1;
                w_use_rs2    = 1'b1;
                case (w_funct3)
                    F3_MEM_B: w_d.mem_size = MEM_SIZE_B;
                    F3_MEM_H: w_d.mem_size = MEM_SIZE_H;
                    F3_MEM_W: w_d.mem_size = MEM_SIZE_W;
                    default:  w_ill = 1'b1;
                endcase
            end
            OP_IMM: begin
                w_d.opsel2 = OPSEL_IMM;
                w_imm_type = IMM_I;
                w_use_rs1  = 1'b1;
                w_use_rd   = 1'b1;
                case (w_funct3)
                    F3_ADD_SUB: w_d.alu_op = ALU_OP_ADD;
                    F3_SLT:     w_d.alu_op = ALU_OP_SLT;
                    F3_SLTU:    w_d.alu_op = ALU_OP_SLTU;
                    F3_XOR:     w_d.alu_op = ALU_OP_XOR;
                    F3_OR:      w_d.alu_op = ALU_OP_OR;
                    F3_AND:     w_d.alu_op = ALU_OP_AND;
                    F3_SLL: begin
                        w_d.alu_op = ALU_OP_SLL;
                        w_imm_type = IMM_SHAMT;
                        w_ill      = (w_funct7 != F7_BASE);
                    end
                    default: begin
                        w_imm_type = IMM_SHAMT;
                        if (w_funct7 == F7_BASE)     w_d.alu_op = ALU_OP_SRL;
                        else if (w_funct7 == F7_ALT) w_d.alu_op = ALU_OP_SRA;
                        else                         w_ill      = 1'b1;
                    end
                endcase
            end
            OP_RTYPE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        F3_ADD_SUB: w_d.alu_op = ALU_OP_ADD;
                        F3_SLL:     w_d.alu_op = ALU_OP_SLL;
                        F3_SLT:     w_d.alu_op = ALU_OP_SLT;
                        F3_SLTU:    w_d.alu_op = ALU_OP_SLTU;
                        F3_XOR:     w_d.alu_op = ALU_OP_XOR;
                        F3_SRL_SRA: w_d.alu_op = ALU_OP_SRL;
                        F3_OR:      w_d.alu_op = ALU_OP_OR;
                        default:    w_d.alu_op = ALU_OP_AND;
                    endcase
                end else if (w_funct7 == F7_ALT) begin
                    // Only SUB and SRA have an alternate encoding.
                    if (w_funct3 == F3_ADD_SUB)      w_d.alu_op = ALU_OP_SUB;
                    else if (w_funct3 == F3_SRL_SRA) w_d.alu_op = ALU_OP_SRA;
                    else                             w_ill      = 1'b1;
                end else if (w_funct7 == F7_MEXT) begin
`ifdef DECODE_MEXT_EN
                    w_d.alu_op = alu_op_e'(5'(ALU_OP_MUL) + {2'b00, w_funct3});
`else
                    w_ill = 1'b1;
`endif
                end else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase

        if (w_ill) begin
            w_d        = DECODE_SET;
            w_d.illegal = 1'b1;
            w_imm_type = IMM_NONE;
            w_use_rs1  = 1'b0;
            w_use_rs2  = 1'b0;
            w_use_rd   = 1'b0;
        end
        w_d.rs1_addr = w_use_rs1 ? i_inst[19:15] : 5'd0;
        w_d.rs2_addr = w_use_rs2 ? i_inst[24:20] : 5'd0;
        w_d.rd_addr  = w_use_rd  ? i_inst[11:7]  : 5'd0;
        w_d.rf_w_en  = w_use_rd && (i_inst[11:7] != 5'd0);
    end

    always_comb begin
        case (w_imm_type)
            IMM_I:     w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            IMM_S:     w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            IMM_B:     w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                                  i_inst[11:8], 1'b0};
            IMM_U:     w_imm32 = {i_inst[31:12], 12'b0};
            IMM_J:     w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                                  i_inst[30:21], 1'b0};
            IMM_SHAMT: w_imm32 = {27'b0, i_inst[24:20]};
            default:   w_imm32 = 32'b0;
        endcase
        o_imm       = {XLEN{w_imm32[31]}};
        o_imm[31:0] = w_imm32;
    end

    assign o_ctrl = w_d;

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: valid/ready handshake in front of a registered ID/EX bundle.
// Define DECODE_MEXT_EN to decode the M extension (ALU_W must then be 5).
module id_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned ALU_W    = ALU_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [31:0]         inst,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [ALU_W-1:0]    alu_func,
    output logic [1:0]          opsel1,
    output logic [1:0]          opsel2,
    output logic [1:0]          wbsel,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    output logic [4:0]          rd_addr,
    output logic                rf_w_en,
    output logic                mem_w_en,
    output logic                mem_r_en,
    output logic [1:0]          mem_size,
    output logic                mem_uns,
    output logic [2:0]          br_type,
    output logic                jalr,
    output logic                illegal,
    output logic [XLEN-1:0]     imm
);

    decode_t               w_ctrl;
    logic [XLEN-1:0]       w_imm;
    logic                  w_accept;
    logic                  r_valid;
    logic [ADDR_LEN-1:0]   r_pc;
    decode_t               r_ctrl;
    logic [XLEN-1:0]       r_imm;

    id_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .i_inst (inst),
        .o_ctrl (w_ctrl),
        .o_imm  (w_imm)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_ctrl  <= DECODE_SET;
            r_imm   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= pc_i;
            r_ctrl  <= w_ctrl;
            r_imm   <= w_imm;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign pc_o      = r_pc;
    assign alu_func  = ALU_W'(r_ctrl.alu_op);
    assign opsel1    = r_ctrl.opsel1;
    assign opsel2    = r_ctrl.opsel2;
    assign wbsel     = r_ctrl.wbsel;
    assign rs1_addr  = r_ctrl.rs1_addr;
    assign rs2_addr  = r_ctrl.rs2_addr;
    assign rd_addr   = r_ctrl.rd_addr;
    // Side effects are gated so a stale payload can never write state.
    assign rf_w_en   = r_ctrl.rf_w_en  && r_valid;
    assign mem_w_en  = r_ctrl.mem_w_en && r_valid;
    assign mem_r_en  = r_ctrl.mem_r_en && r_valid;
    assign mem_size  = r_ctrl.mem_size;
    assign mem_uns   = r_ctrl.mem_uns;
    assign br_type   = r_ctrl.br_type;
    assign jalr      = r_ctrl.jalr;
    assign illegal   = r_ctrl.illegal;
    assign imm       = r_imm;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected ops queued on accept, compared on consume.
module tb_id_stage;

`ifdef DECODE_MEXT_EN
    localparam int unsigned ALU_W = 5;
`else
    localparam int unsigned ALU_W = 4;
`endif

    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SRA = 5'd7, A_MUL = 5'd10;
    localparam logic [1:0] O1_RS1 = 2'd0, O1_PC = 2'd1, O1_ZERO = 2'd2;
    localparam logic [1:0] O2_RS2 = 2'd0, O2_IMM = 2'd1;
    localparam logic [1:0] W_ALU = 2'd0, W_MEM = 2'd1, W_PC4 = 2'd2;
    localparam logic [2:0] B_NONE = 3'd0, B_EQ = 3'd1, B_JUMP = 3'd7;
    localparam logic [1:0] SZ_B = 2'd0, SZ_W = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [1:0]  op1;
        logic [1:0]  op2;
        logic [1:0]  wb;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf;
        logic        mw;
        logic        mr;
        logic [1:0]  sz;
        logic        uns;
        logic [2:0]  br;
        logic        jr;
        logic        ill;
        logic [31:0] imm;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      pc_i = '0;
    logic [31:0]      inst = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      pc_o;
    logic [ALU_W-1:0] alu_func;
    logic [1:0]       opsel1, opsel2, wbsel, mem_size;
    logic [4:0]       rs1_addr, rs2_addr, rd_addr;
    logic             rf_w_en, mem_w_en, mem_r_en, mem_uns, jalr, illegal;
    logic [2:0]       br_type;
    logic [31:0]      imm;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_stage #(
        .XLEN     (32),
        .ADDR_LEN (32),
        .ALU_W    (ALU_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_i      (pc_i),
        .inst      (inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_o      (pc_o),
        .alu_func  (alu_func),
        .opsel1    (opsel1),
        .opsel2    (opsel2),
        .wbsel     (wbsel),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (rd_addr),
        .rf_w_en   (rf_w_en),
        .mem_w_en  (mem_w_en),
        .mem_r_en  (mem_r_en),
        .mem_size  (mem_size),
        .mem_uns   (mem_uns),
        .br_type   (br_type),
        .jalr      (jalr),
        .illegal   (illegal),
        .imm       (imm)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] alu,
                                input logic [1:0] op1, input logic [1:0] op2,
                                input logic [1:0] wb, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic rf,
                                input logic mw, input logic mr, input logic [1:0] sz,
                                input logic uns, input logic [2:0] br, input logic jr,
                                input logic ill, input logic [31:0] im);
        exp_t e;
        e = '{pc: pc, alu: alu, op1: op1, op2: op2, wb: wb, rs1: rs1, rs2: rs2, rd: rd,
              rf: rf, mw: mw, mr: mr, sz: sz, uns: uns, br: br, jr: jr, ill: ill, imm: im};
        return e;
    endfunction

    function automatic exp_t ill_op(input logic [31:0] pc);
        return mk(pc, A_ADD, O1_RS1, O2_RS2, W_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                  SZ_B, 1'b0, B_NONE, 1'b0, 1'b1, 32'd0);
    endfunction

    // Consumer side: an op leaves the stage on out_valid & out_ready (unless killed).
    always @(negedge clk) begin
        exp_t e, a;
        if (!reset && !flush && out_valid === 1'b1 && out_ready) begin
            n_vec++;
            a = '{pc: pc_o, alu: 5'(alu_func), op1: opsel1, op2: opsel2, wb: wbsel,
                  rs1: rs1_addr, rs2: rs2_addr, rd: rd_addr, rf: rf_w_en, mw: mem_w_en,
                  mr: mem_r_en, sz: mem_size, uns: mem_uns, br: br_type, jr: jalr,
                  ill: illegal, imm: imm};
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_op pc=%h got %h required none", pc_o, a);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL op pc=%h got %h required %h", e.pc, a, e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] pc, input exp_t e);
        bit acc = 1'b0;
        inst     = i;
        pc_i     = pc;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && !flush && !reset) begin
                sb.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout pc=%h got in_ready=%b required 1", pc, in_ready);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_drained(input string tag);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0 || out_valid !== 1'b0 || rf_w_en !== 1'b0) begin
            n_err++;
            $display("FAIL %s pending=%0d out_valid=%b rf_w_en=%b required 0/0/0",
                     tag, sb.size(), out_valid, rf_w_en);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, rf_w_en, mem_w_en, illegal, br_type, pc_o, imm} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b rf=%b mw=%b ill=%b br=%0d pc=%h imm=%h required 0",
                     out_valid, rf_w_en, mem_w_en, illegal, br_type, pc_o, imm);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        out_ready = 1'b1;
        send(32'h00500093, 32'h0, mk(32'h0, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd0, 5'd0, 5'd1,
             1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd5));
        send(32'h002081B3, 32'h4, mk(32'h4, A_ADD, O1_RS1, O2_RS2, W_ALU, 5'd1, 5'd2, 5'd3,
             1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd0));
        send(32'h402081B3, 32'h8, mk(32'h8, A_SUB, O1_RS1, O2_RS2, W_ALU, 5'd1, 5'd2, 5'd3,
             1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd0));
        send(32'h40335293, 32'hC, mk(32'hC, A_SRA, O1_RS1, O2_IMM, W_ALU, 5'd6, 5'd0, 5'd5,
             1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd3));
        send(32'h123453B7, 32'h10, mk(32'h10, A_ADD, O1_ZERO, O2_IMM, W_ALU, 5'd0, 5'd0, 5'd7,
             1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'h12345000));
        // rd = x0 must not write the register file.
        send(32'h00000013, 32'h14, mk(32'h14, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd0, 5'd0, 5'd0,
             1'b0, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd0));
        idle(2);
    endtask

    task automatic test_mem();
        send(32'h0020A423, 32'h20, mk(32'h20, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd1, 5'd2, 5'd0,
             1'b0, 1'b1, 1'b0, SZ_W, 1'b0, B_NONE, 1'b0, 1'b0, 32'd8));
        send(32'hFFF14203, 32'h24, mk(32'h24, A_ADD, O1_RS1, O2_IMM, W_MEM, 5'd2, 5'd0, 5'd4,
             1'b1, 1'b0, 1'b1, SZ_B, 1'b1, B_NONE, 1'b0, 1'b0, 32'hFFFFFFFF));
        idle(2);
    endtask

    task automatic test_branch();
        send(32'hFE000EE3, 32'h30, mk(32'h30, A_SUB, O1_RS1, O2_RS2, W_ALU, 5'd0, 5'd0, 5'd0,
             1'b0, 1'b0, 1'b0, SZ_B, 1'b0, B_EQ, 1'b0, 1'b0, 32'hFFFFFFFC));
        send(32'h008000EF, 32'h34, mk(32'h34, A_ADD, O1_PC, O2_IMM, W_PC4, 5'd0, 5'd0, 5'd1,
             1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_JUMP, 1'b0, 1'b0, 32'd8));
        idle(2);
    endtask

    task automatic test_illegal();
        send(32'hFFFFFFFF, 32'h40, ill_op(32'h40));
        send(32'h00000000, 32'h44, ill_op(32'h44));
        send(32'h00003083, 32'h48, ill_op(32'h48));
        send(32'h40109093, 32'h4C, ill_op(32'h4C));
`ifdef DECODE_MEXT_EN
        send(32'h022081B3, 32'h50, mk(32'h50, A_MUL, O1_RS1, O2_RS2, W_ALU, 5'd1, 5'd2, 5'd3,
             1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd0));
`else
        send(32'h022081B3, 32'h50, ill_op(32'h50));
`endif
        idle(2);
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        send(32'h00100093, 32'h100, mk(32'h100, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd0, 5'd0,
             5'd1, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd1));
        inst     = 32'h00200113;
        pc_i     = 32'h104;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_o !== 32'h100 || imm !== 32'd1
                || rd_addr !== 5'd1) begin
                n_err++;
                $display("FAIL stall_hold got rdy=%b v=%b pc=%h imm=%h rd=%0d required 0/1/100/1/1",
                         in_ready, out_valid, pc_o, imm, rd_addr);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h00200113, 32'h104, mk(32'h104, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd0, 5'd0,
             5'd2, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd2));
        send(32'h00300193, 32'h108, mk(32'h108, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd0, 5'd0,
             5'd3, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd3));
        idle(2);
        check_drained("stall_release");
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    logic [4:0]  rd = 5'(k % 31 + 1);
                    logic [31:0] pc = 32'h200 + 32'(4 * k);
                    send((32'(k) << 20) | (32'(rd) << 7) | 32'h13, pc,
                         mk(pc, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd0, 5'd0, rd, 1'b1, 1'b0,
                            1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'(k)));
                end
                idle(1);
            end
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        idle(3);
        check_drained("random_ready");
    endtask

    task automatic test_flush_reset();
        // Flush kills both the held op and the one offered in the same cycle.
        out_ready = 1'b0;
        send(32'h00500093, 32'h300, mk(32'h300, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd0, 5'd0,
             5'd1, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_NONE, 1'b0, 1'b0, 32'd5));
        inst      = 32'h00700393;
        pc_i      = 32'h304;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        sb.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_drained("flush_kill");
        check_drained("flush_no_replay");
        // Reset mid-stream behaves the same way.
        out_ready = 1'b0;
        send(32'h0020A423, 32'h310, mk(32'h310, A_ADD, O1_RS1, O2_IMM, W_ALU, 5'd1, 5'd2,
             5'd0, 1'b0, 1'b1, 1'b0, SZ_W, 1'b0, B_NONE, 1'b0, 1'b0, 32'd8));
        inst     = 32'h00500093;
        pc_i     = 32'h314;
        in_valid = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        sb.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || mem_w_en !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid got v=%b mw=%b rdy=%b required 0/0/1",
                     out_valid, mem_w_en, in_ready);
        end
        @(posedge clk);
        #1;
        send(32'h008000EF, 32'h320, mk(32'h320, A_ADD, O1_PC, O2_IMM, W_PC4, 5'd0, 5'd0,
             5'd1, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0, B_JUMP, 1'b0, 1'b0, 32'd8));
        idle(2);
        check_drained("recover");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal();
        test_back_pressure();
        test_back_to_back();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
